// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//   Fetch stage. A PC walks instruction memory one read at a time over a
//   req/ack handshake. Each returned word is buffered together with its PC in
//   a DEPTH-entry queue, and the queue head is offered to decode through a
//   valid/ready handshake. A redirect flushes the queue and restarts fetch. If
//   the redirect arrives while a read is still outstanding, that read is
//   completed and its data thrown away. Freeze stops new reads from being
//   issued, but it does not cancel a read that is already outstanding.
//
// Ports
//   clk, rst        clock; synchronous active-low reset
//   imem_req/addr   read request and address (address held while req is high)
//   imem_ack/data   read completion and data
//   redirect(_pc)   flush and restart fetch at redirect_pc
//   freeze          suppress issue of new requests
//   inst_valid/inst/inst_pc/inc_pc   queue head presented to decode
//   inst_ready      decode takes the head this cycle
//   err             sticky PC-wrap error
//   count           queue occupancy
// -----------------------------------------------------------------------------
module fetch_queue #(
   parameter int          DATA_W   = 16,
   parameter int          ADDR_W   = 16,
   parameter int          DEPTH    = 4,
   parameter int unsigned RESET_PC = 0,
   parameter int          PC_INC   = 2,
   localparam int         PTR_W    = $clog2(DEPTH),
   localparam int         CNT_W    = PTR_W + 1
) (
   input  logic              clk,
   input  logic              rst,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [DATA_W-1:0] imem_data,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_pc,
   input  logic              freeze,
   output logic              inst_valid,
   output logic [DATA_W-1:0] inst,
   output logic [ADDR_W-1:0] inst_pc,
   output logic [ADDR_W-1:0] inc_pc,
   input  logic              inst_ready,
   output logic              err,
   output logic [CNT_W-1:0]  count
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DRAIN} state_t;

   state_t            r_state;
   logic [ADDR_W-1:0] r_pc;
   logic [ADDR_W-1:0] r_drain_pc;   // address of the read being discarded
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [CNT_W-1:0]  r_count;
   logic              r_err;
   logic [DATA_W-1:0] r_mem_data [DEPTH];
   logic [ADDR_W-1:0] r_mem_pc   [DEPTH];

   logic              w_req;
   logic              w_ack;
   logic              w_push;
   logic              w_pop;
   logic [ADDR_W:0]   w_pc_sum;

   // NOTE: every signal written in an always_comb gets a default first, so no
   // path through the block can leave it unassigned and infer a latch.
   always_comb begin
      w_req = 1'b1;
      if (r_state == S_IDLE)
         w_req = (r_count < CNT_W'(DEPTH)) && !freeze;
   end

   // Request and head-valid are forced low while reset is asserted, so any
   // read that was in flight when reset arrived is abandoned.
   assign imem_req   = rst && w_req;
   assign imem_addr  = (r_state == S_DRAIN) ? r_drain_pc : r_pc;
   assign inst_valid = rst && (r_count != '0);

   assign w_ack    = imem_req && imem_ack;
   assign w_push   = w_ack && (r_state != S_DRAIN) && !redirect;
   assign w_pop    = inst_valid && inst_ready && !redirect;
   // The extra top bit is the carry out of the PC add and feeds the wrap error.
   assign w_pc_sum = {1'b0, r_pc} + (ADDR_W+1)'(PC_INC);

   assign inst    = r_mem_data[r_rd_ptr];
   assign inst_pc = r_mem_pc[r_rd_ptr];
   assign inc_pc  = inst_pc + ADDR_W'(PC_INC);
   assign err     = r_err;
   assign count   = r_count;

   // NOTE: queue storage has no reset. Only the pointers and the count define
   // which entries are live, so resetting the array would add reset fan-out
   // without changing any behaviour.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_data[r_wr_ptr] <= imem_data;
         r_mem_pc[r_wr_ptr]   <= r_pc;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // right-hand side in this block sees the values from before the clock edge.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state    <= S_IDLE;
         r_pc       <= ADDR_W'(RESET_PC);
         r_drain_pc <= ADDR_W'(RESET_PC);
         r_rd_ptr   <= '0;
         r_wr_ptr   <= '0;
         r_count    <= '0;
         r_err      <= 1'b0;
      end else if (redirect) begin
         r_count  <= '0;
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_pc     <= redirect_pc;
         if (imem_req && !imem_ack) begin
            r_state <= S_DRAIN;
            // A second redirect while draining keeps the original read address.
            if (r_state != S_DRAIN)
               r_drain_pc <= r_pc;
         end else begin
            r_state <= S_IDLE;
         end
      end else begin
         case (r_state)
            S_IDLE:  if (imem_req && !imem_ack) r_state <= S_WAIT;
            S_WAIT:  if (imem_ack)              r_state <= S_IDLE;
            S_DRAIN: if (imem_ack)              r_state <= S_IDLE;
            default:                            r_state <= S_IDLE;
         endcase

         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            r_pc     <= w_pc_sum[ADDR_W-1:0];
            if (w_pc_sum[ADDR_W])
               r_err <= 1'b1;
         end
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);

         r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_fetch_queue
//   Directed testbench for fetch_queue. A memory model with programmable ack
//   latency answers the reads. A transaction-level model of the fetch stage
//   (a queue of {word, pc} entries, the next PC, and flags for an outstanding
//   read and a read to be discarded) is compared against the DUT at every
//   falling edge. Hand-computed literal checks pin specific points in each
//   scenario.
// -----------------------------------------------------------------------------
module tb_fetch_queue;

   localparam int DW    = 16;
   localparam int AW    = 16;
   localparam int DEPTH = 4;
   localparam logic [DW-1:0] DKEY = 16'hC3C3;   // memory word = address ^ DKEY

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          imem_req;
   logic [AW-1:0] imem_addr;
   logic          imem_ack;
   logic [DW-1:0] imem_data;
   logic          redirect = 1'b0;
   logic [AW-1:0] redirect_pc = '0;
   logic          freeze = 1'b0;
   logic          inst_valid;
   logic [DW-1:0] inst;
   logic [AW-1:0] inst_pc;
   logic [AW-1:0] inc_pc;
   logic          inst_ready = 1'b0;
   logic          err;
   logic [2:0]    count;

   int n_vec  = 0;
   int n_miss = 0;

   fetch_queue #(
      .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .RESET_PC(0), .PC_INC(2)
   ) dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_data(imem_data),
      .redirect(redirect), .redirect_pc(redirect_pc), .freeze(freeze),
      .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inc_pc(inc_pc),
      .inst_ready(inst_ready), .err(err), .count(count)
   );

   always #5 clk = ~clk;

   // Memory model: a read is acked once it has been waiting for `lat` cycles.
   // When req drops, the wait counter clears, so an abandoned read is forgotten.
   int lat  = 0;
   int wcnt = 0;
   always @(posedge clk) begin
      if (!imem_req || imem_ack) wcnt <= 0;
      else                       wcnt <= wcnt + 1;
   end
   assign imem_ack  = imem_req && (wcnt >= lat);
   assign imem_data = imem_addr ^ DKEY;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [DW-1:0] d;
      logic [AW-1:0] pc;
   } ent_t;

   ent_t          q[$];
   logic [AW-1:0] m_pc    = '0;
   logic [AW-1:0] m_drain = '0;
   bit            m_out   = 1'b0;   // a read is outstanding
   bit            m_disc  = 1'b0;   // the outstanding read is to be discarded
   bit            m_err   = 1'b0;
   bit            mon_on  = 1'b0;

   function automatic bit exp_req();
      return rst && (m_out || (q.size() < DEPTH && !freeze));
   endfunction

   always @(posedge clk) begin : model
      bit acc;
      bit pop;
      if (!rst) begin
         q.delete();
         m_pc   = '0;
         m_out  = 1'b0;
         m_disc = 1'b0;
         m_err  = 1'b0;
         mon_on = 1'b1;
      end else begin
         acc = exp_req() && imem_ack;
         pop = (q.size() != 0) && inst_ready;
         if (redirect) begin
            if (exp_req() && !imem_ack) begin
               if (!m_disc) m_drain = m_pc;
               m_out  = 1'b1;
               m_disc = 1'b1;
            end else begin
               m_out  = 1'b0;
               m_disc = 1'b0;
            end
            q.delete();
            m_pc = redirect_pc;
         end else begin
            if (pop) void'(q.pop_front());
            if (acc) begin
               if (!m_disc) begin
                  q.push_back('{d: imem_data, pc: m_pc});
                  if (int'(m_pc) + 2 > 65535) m_err = 1'b1;
                  m_pc = m_pc + 16'd2;
               end
               m_out  = 1'b0;
               m_disc = 1'b0;
            end else if (exp_req()) begin
               m_out = 1'b1;
            end
         end
      end
   end

   // Cycle-by-cycle compare against the model.
   always @(negedge clk) begin : compare
      logic [AW-1:0] exp_inc;
      if (mon_on) begin
         check("req", imem_req, exp_req());
         check("addr", imem_addr, m_disc ? m_drain : m_pc);
         check("valid", inst_valid, rst && (q.size() != 0));
         check("count", count, q.size());
         check("err", err, m_err);
         if (rst && q.size() != 0) begin
            exp_inc = q[0].pc + 16'd2;
            check("inst", inst, q[0].d);
            check("inst_pc", inst_pc, q[0].pc);
            check("inc_pc", inc_pc, exp_inc);
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst      = 1'b0;
      redirect = 1'b0;
      freeze   = 1'b0;
      tick();
      tick();
      @(negedge clk);
      check("rst_count", count, 0);
      check("rst_req", imem_req, 0);
      check("rst_valid", inst_valid, 0);
      check("rst_err", err, 0);
      tick();
      rst = 1'b1;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin : stim
      // 1: zero-wait memory, decode always ready.
      lat = 0; inst_ready = 1'b1;
      do_reset();
      @(negedge clk);
      check("t1_addr0", imem_addr, 16'h0000);
      check("t1_cnt0", count, 0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("t1_pc", inst_pc, 2 * k);
         check("t1_inc", inc_pc, 2 * k + 2);
         check("t1_cnt", count, 1);
      end

      // 2: decode stalled, queue fills, one pop refills.
      inst_ready = 1'b0;
      do_reset();
      repeat (4) @(posedge clk);
      @(negedge clk);
      check("t2_full", count, 4);
      check("t2_req", imem_req, 0);
      check("t2_addr", imem_addr, 16'h0008);
      tick();
      inst_ready = 1'b1;
      @(negedge clk);
      check("t2_head", inst_pc, 16'h0000);
      tick();
      inst_ready = 1'b0;
      @(negedge clk);
      check("t2_cnt3", count, 3);
      check("t2_refill", imem_req, 1);
      check("t2_head2", inst_pc, 16'h0002);
      @(negedge clk);
      check("t2_cnt4", count, 4);

      // 3: 3-cycle latency, redirect during the second wait cycle.
      lat = 3;
      do_reset();
      tick();
      tick();
      redirect = 1'b1; redirect_pc = 16'h0100;
      tick();
      redirect = 1'b0;
      @(negedge clk);
      check("t3_drain_req", imem_req, 1);
      check("t3_drain_addr", imem_addr, 16'h0000);
      check("t3_empty", count, 0);
      @(negedge clk);
      check("t3_new_addr", imem_addr, 16'h0100);
      check("t3_no_push", count, 0);
      for (int i = 0; i < 20 && !inst_valid; i++) @(negedge clk);
      check("t3_fill", inst_valid, 1);
      check("t3_pc", inst_pc, 16'h0100);
      check("t3_inst", inst, 16'h0100 ^ DKEY);
      check("t3_cnt", count, 1);

      // 4: redirect together with ack and pop at count=2.
      lat = 0; inst_ready = 1'b0;
      do_reset();
      tick();
      tick();
      inst_ready = 1'b1; redirect = 1'b1; redirect_pc = 16'h0040;
      @(negedge clk);
      check("t4_cnt2", count, 2);
      tick();
      inst_ready = 1'b0; redirect = 1'b0;
      @(negedge clk);
      check("t4_cnt0", count, 0);
      check("t4_valid", inst_valid, 0);
      check("t4_addr", imem_addr, 16'h0040);
      @(negedge clk);
      check("t4_pc", inst_pc, 16'h0040);

      // 5: PC wrap sets a sticky error that reset clears.
      tick();
      redirect = 1'b1; redirect_pc = 16'hFFFE;
      tick();
      redirect = 1'b0;
      @(negedge clk);
      check("t5_addr", imem_addr, 16'hFFFE);
      check("t5_err0", err, 0);
      @(negedge clk);
      check("t5_pc", inst_pc, 16'hFFFE);
      check("t5_inc", inc_pc, 16'h0000);
      check("t5_err1", err, 1);
      repeat (6) @(negedge clk);
      check("t5_sticky", err, 1);
      do_reset();
      @(negedge clk);
      check("t5_rst_addr", imem_addr, 16'h0000);
      check("t5_rst_err", err, 0);

      // 6: freeze during WAIT.
      lat = 3; inst_ready = 1'b0;
      do_reset();
      tick();
      freeze = 1'b1;
      @(negedge clk);
      check("t6_held", imem_req, 1);
      tick();
      tick();
      tick();
      @(negedge clk);
      check("t6_frozen", imem_req, 0);
      check("t6_cnt1", count, 1);
      check("t6_pc", inst_pc, 16'h0000);
      repeat (3) @(negedge clk);
      check("t6_still", imem_req, 0);
      tick();
      inst_ready = 1'b1;
      tick();
      inst_ready = 1'b0;
      @(negedge clk);
      check("t6_drained", count, 0);
      check("t6_noreq", imem_req, 0);
      tick();
      freeze = 1'b0;
      @(negedge clk);
      check("t6_resume", imem_req, 1);
      check("t6_addr", imem_addr, 16'h0002);

      repeat (2) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
